// File: rtl/ghash_engine.sv
// Digit-serial GHASH accumulator: acc = (acc ^ X) * H in GF(2^128), DIGIT multiplier bits per cycle.
// Optional macro GHASH_ABORT_EN adds a synchronous abort input that clears the message state.
module ghash_engine #(
    parameter int unsigned DIGIT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef GHASH_ABORT_EN
    input  logic         abort,
`endif
    input  logic [127:0] h_in,
    input  logic         h_load,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [127:0] blk_data,
    input  logic         blk_last,
    output logic         tag_valid,
    input  logic         tag_ready,
    output logic [127:0] tag,
    output logic         busy
);

    localparam int unsigned W     = 128;
    localparam int unsigned N     = W / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] POLY = W'(8'h87);

    typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

    state_t           state_q, state_n;
    logic [W-1:0]     h_q, acc_q, a_q, m_q, p_q;
    logic [W-1:0]     p_step, m_step;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;
    logic             accept, mul_done, tag_take, abort_c;

`ifdef GHASH_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Multiply by alpha: shift toward higher powers and fold bit 127 back through the polynomial.
    function automatic logic [W-1:0] mul_alpha(input logic [W-1:0] v);
        return {v[W-2:0], 1'b0} ^ (v[W-1] ? POLY : '0);
    endfunction

    // One digit of the product: consume the DIGIT lowest unconsumed bits of a, LSB first.
    always_comb begin
        p_step = p_q;
        m_step = m_q;
        for (int unsigned j = 0; j < DIGIT; j++) begin
            if (a_q[j]) p_step = p_step ^ m_step;
            m_step = mul_alpha(m_step);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n  = state_q;
        accept   = 1'b0;
        mul_done = 1'b0;
        tag_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (blk_valid && blk_ready) begin
                    accept  = 1'b1;
                    state_n = MUL;
                end
            end
            MUL: begin
                if (cnt_q == CNT_W'(N - 1)) begin
                    mul_done = 1'b1;
                    state_n  = last_q ? OUT : IDLE;
                end
            end
            OUT: begin
                if (tag_ready) begin
                    tag_take = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Abort wins over any handshake or completion in the same cycle.
        if (abort_c) begin
            accept   = 1'b0;
            mul_done = 1'b0;
            tag_take = 1'b0;
            state_n  = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q       <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            m_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            tag       <= '0;
            blk_ready <= 1'b0;
            tag_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (state_q == IDLE && h_load) h_q <= h_in;

            if (accept) begin
                a_q    <= acc_q ^ blk_data;
                m_q    <= h_load ? h_in : h_q;
                p_q    <= '0;
                cnt_q  <= '0;
                last_q <= blk_last;
            end else if (state_q == MUL) begin
                a_q   <= a_q >> DIGIT;
                m_q   <= m_step;
                p_q   <= p_step;
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (abort_c || tag_take) acc_q <= '0;
            else if (mul_done)       acc_q <= p_step;

            if (mul_done && last_q) tag <= p_step;

            blk_ready <= (state_n == IDLE);
            tag_valid <= (state_n == OUT);
            busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_ghash_engine.sv
// Randomized self-checking bench for ghash_engine against a GF(2^128) reference model.
module tb_ghash_engine;

    localparam int unsigned DIGIT = 8;
    localparam int N = 128 / DIGIT;

    logic         clk = 1'b0;
    logic         rst_n, h_load, blk_valid, blk_last, tag_ready, abort;
    logic [127:0] h_in, blk_data;
    logic         blk_ready, tag_valid, busy;
    logic [127:0] tag;

    logic         sw_h_load, sw_blk_valid, sw_blk_last, sw_tag_ready;
    logic [127:0] sw_h_in, sw_blk_data;
    logic         s1_blk_ready, s1_tag_valid, s1_busy;
    logic [127:0] s1_tag;
    logic         s128_blk_ready, s128_tag_valid, s128_busy;
    logic [127:0] s128_tag;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ghash_engine #(.DIGIT(DIGIT)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef GHASH_ABORT_EN
        .abort(abort),
`endif
        .h_in(h_in), .h_load(h_load), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_data(blk_data), .blk_last(blk_last), .tag_valid(tag_valid),
        .tag_ready(tag_ready), .tag(tag), .busy(busy)
    );

    ghash_engine #(.DIGIT(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n),
`ifdef GHASH_ABORT_EN
        .abort(1'b0),
`endif
        .h_in(sw_h_in), .h_load(sw_h_load), .blk_valid(sw_blk_valid), .blk_ready(s1_blk_ready),
        .blk_data(sw_blk_data), .blk_last(sw_blk_last), .tag_valid(s1_tag_valid),
        .tag_ready(sw_tag_ready), .tag(s1_tag), .busy(s1_busy)
    );

    ghash_engine #(.DIGIT(128)) dut_d128 (
        .clk(clk), .rst_n(rst_n),
`ifdef GHASH_ABORT_EN
        .abort(1'b0),
`endif
        .h_in(sw_h_in), .h_load(sw_h_load), .blk_valid(sw_blk_valid), .blk_ready(s128_blk_ready),
        .blk_data(sw_blk_data), .blk_last(sw_blk_last), .tag_valid(s128_tag_valid),
        .tag_ready(sw_tag_ready), .tag(s128_tag), .busy(s128_busy)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Field product as the XOR of a*alpha^i over the set bits of b.
    function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r = '0;
        logic [127:0] s = a;
        for (int i = 0; i < 128; i++) begin
            if (b[i]) r ^= s;
            s = {s[126:0], 1'b0} ^ (s[127] ? 128'h87 : 128'h0);
        end
        return r;
    endfunction

    function automatic logic [127:0] ghash(input logic [127:0] blocks[$], input logic [127:0] h);
        logic [127:0] acc = '0;
        foreach (blocks[i]) acc = gf_mul(acc ^ blocks[i], h);
        return acc;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic load_h(input logic [127:0] h);
        h_in = h;
        h_load = 1'b1;
        @(negedge clk);
        h_load = 1'b0;
    endtask

    task automatic send(input logic [127:0] x, input logic last, input logic with_h, input logic [127:0] h);
        int k = 0;
        while (!blk_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!blk_ready) check("blk_ready_timeout", 128'(blk_ready), 128'h1);
        blk_data  = x;
        blk_last  = last;
        blk_valid = 1'b1;
        if (with_h) begin
            h_in   = h;
            h_load = 1'b1;
        end
        @(negedge clk);
        blk_valid = 1'b0;
        h_load    = 1'b0;
    endtask

    task automatic wait_tag(input string name, input logic [127:0] exp);
        int k = 0;
        while (!tag_valid && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({name, "_lat"}, 128'(k), 128'(N));
        check({name, "_tag"}, tag, exp);
    endtask

    task automatic take_tag(input string name);
        tag_ready = 1'b1;
        @(negedge clk);
        tag_ready = 1'b0;
        check({name, "_tv_clr"}, 128'(tag_valid), 128'h0);
        check({name, "_rdy"}, 128'(blk_ready), 128'h1);
        check({name, "_idle"}, 128'(busy), 128'h0);
    endtask

    initial begin
        logic [127:0] h, x, y, exp_t;
        logic [127:0] q[$];
        int k, nblk, lat1, lat128;
        logic [127:0] t1, t128;

        rst_n = 1'b0; h_load = 1'b0; blk_valid = 1'b0; blk_last = 1'b0; tag_ready = 1'b0;
        abort = 1'b0; h_in = '0; blk_data = '0;
        sw_h_load = 1'b0; sw_blk_valid = 1'b0; sw_blk_last = 1'b0; sw_tag_ready = 1'b1;
        sw_h_in = '0; sw_blk_data = '0;

        repeat (3) @(negedge clk);
        check("rst_blk_ready", 128'(blk_ready), 128'h0);
        check("rst_tag_valid", 128'(tag_valid), 128'h0);
        check("rst_busy", 128'(busy), 128'h0);
        check("rst_tag", tag, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 128'(blk_ready), 128'h1);

        // Identity and reduction
        load_h(128'h1);
        send(128'h5, 1'b1, 1'b0, '0);
        check("ident_busy", 128'(busy), 128'h1);
        check("ident_rdy_low", 128'(blk_ready), 128'h0);
        wait_tag("ident", 128'h5);
        take_tag("ident");
        load_h(128'h2);
        send(128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b1, 1'b0, '0);
        wait_tag("reduce", 128'h87);
        take_tag("reduce");

        // Chaining, with h_load ignored while multiplying
        load_h(128'h1);
        send(128'h3, 1'b0, 1'b0, '0);
        h_in = rand128();
        h_load = 1'b1;
        k = 0;
        while (!blk_ready && k < 400) begin
            @(negedge clk);
            h_load = 1'b0;
            k++;
        end
        check("chain_ready_lat", 128'(k), 128'(N));
        send(128'h5, 1'b1, 1'b0, '0);
        wait_tag("chain", 128'h6);
        take_tag("chain");
        send(128'h9, 1'b1, 1'b0, '0);
        wait_tag("chain_new", 128'h9);
        take_tag("chain_new");

        // Backpressure, with h_load ignored while the tag is pending
        h = rand128();
        x = rand128();
        load_h(h);
        send(x, 1'b1, 1'b0, '0);
        exp_t = gf_mul(x, h);
        wait_tag("bp", exp_t);
        for (int i = 0; i < 5; i++) begin
            h_in = rand128();
            h_load = 1'b1;
            @(negedge clk);
            h_load = 1'b0;
            check("bp_tv", 128'(tag_valid), 128'h1);
            check("bp_tag", tag, exp_t);
            check("bp_rdy", 128'(blk_ready), 128'h0);
        end
        take_tag("bp");
        y = rand128();
        send(y, 1'b1, 1'b0, '0);
        wait_tag("h_keep", gf_mul(y, h));
        take_tag("h_keep");

        // H load in the same cycle as the block
        h = rand128();
        x = rand128();
        send(x, 1'b1, 1'b1, h);
        wait_tag("same_cyc_h", gf_mul(x, h));
        take_tag("same_cyc_h");

        // Random multi-block messages
        for (int m = 0; m < 6; m++) begin
            if ($urandom_range(0, 1) == 1) begin
                h = rand128();
                load_h(h);
            end
            nblk = $urandom_range(1, 4);
            q.delete();
            for (int b = 0; b < nblk; b++) q.push_back(rand128());
            for (int b = 0; b < nblk; b++) send(q[b], 1'(b == nblk - 1), 1'b0, '0);
            wait_tag("rand_msg", ghash(q, h));
            take_tag("rand_msg");
        end

`ifdef GHASH_ABORT_EN
        x = rand128();
        send(x, 1'b0, 1'b0, '0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", 128'(busy), 128'h0);
        check("abort_rdy", 128'(blk_ready), 128'h1);
        abort = 1'b1;
        blk_valid = 1'b1;
        blk_data = rand128();
        blk_last = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        blk_valid = 1'b0;
        check("abort_blocks_hs", 128'(busy), 128'h0);
        y = rand128();
        send(y, 1'b1, 1'b0, '0);
        wait_tag("abort_after", gf_mul(y, h));
        take_tag("abort_after");
`endif

        // Reset during MUL
        send(rand128(), 1'b1, 1'b0, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", 128'(blk_ready), 128'h0);
        check("mid_rst_tv", 128'(tag_valid), 128'h0);
        check("mid_rst_busy", 128'(busy), 128'h0);
        check("mid_rst_tag", tag, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(rand128(), 1'b1, 1'b0, '0);
        wait_tag("h_cleared", 128'h0);
        take_tag("h_cleared");

        // DIGIT sweep: latency and value for DIGIT=1 and DIGIT=128
        for (int t = 0; t < 3; t++) begin
            h = rand128();
            x = rand128();
            check("sw_rdy1", 128'(s1_blk_ready), 128'h1);
            check("sw_rdy128", 128'(s128_blk_ready), 128'h1);
            sw_h_in = h; sw_h_load = 1'b1;
            sw_blk_data = x; sw_blk_last = 1'b1; sw_blk_valid = 1'b1;
            @(negedge clk);
            sw_h_load = 1'b0; sw_blk_valid = 1'b0;
            lat1 = -1; lat128 = -1; t1 = '0; t128 = '0;
            for (int c = 0; c < 140; c++) begin
                if (s1_tag_valid && lat1 < 0) begin lat1 = c; t1 = s1_tag; end
                if (s128_tag_valid && lat128 < 0) begin lat128 = c; t128 = s128_tag; end
                @(negedge clk);
            end
            check("sw_lat_d1", 128'(lat1), 128'(128));
            check("sw_lat_d128", 128'(lat128), 128'(1));
            check("sw_tag_d1", t1, gf_mul(x, h));
            check("sw_tag_d128", t128, gf_mul(x, h));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
